fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch/PC sequencer: drives opCode/funct into the control decoder and consumes its Branch/Jump/Exception/irq results.
//  Owns the PC, performs a req/ack fetch from instruction memory, holds each instruction until execute retires it, then redirects.
//  Sits between imem and ctl; provides pc_plus4 for jal link and epc for exception/interrupt return.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC loaded on reset
//  EXC_VECTOR  32'h0000_0180  PC loaded on Exception
//  IRQ_VECTOR  32'h0000_0200  PC loaded on taken interrupt
// PORTS
//  clk           in   1   clock, rising edge
//  reset_n       in   1   asynchronous, active-low reset
//  imem_req      out  1   fetch request; held with imem_addr stable until imem_ack
//  imem_addr     out  32  fetch address (= pc)
//  imem_ack      in   1   imem_rdata valid this cycle
//  imem_rdata    in   32  fetched word
//  instr         out  32  held instruction
//  opCode        out  6   instr[31:26], to ctl
//  funct         out  6   instr[5:0], to ctl
//  instr_valid   out  1   instr/opCode/funct valid; ctl outputs meaningful
//  ex_done       in   1   execute retires held instr this cycle
//  Branch        in   1   from ctl
//  Jump          in   2   from ctl: 00 seq, 01 branch, 10 j/jal, 11 jr
//  branch_taken  in   1   ALU compare result for beq/bne
//  rs_data       in   32  jr target
//  Exception     in   1   from ctl: illegal instruction
//  irq           in   1   external interrupt, level
//  pc_plus4      out  32  pc + 4
//  epc           out  32  return PC captured on Exception/irq
//  irq_ack       out  1   one-cycle pulse when irq taken
// BEHAVIOUR
//  Reset (async assert): state=IDLE, pc=RESET_PC, instr=0, epc=0, irq_pend=0; all outputs 0 except imem_addr=RESET_PC, pc_plus4=RESET_PC+4.
//  FSM: IDLE -> FETCH (unconditional, first edge after reset_n rises); FETCH -> ISSUE on imem_ack (instr<=imem_rdata);
//       ISSUE -> FETCH on ex_done (pc<=next_pc). imem_req=(state==FETCH); instr_valid=(state==ISSUE).
//  Latency: ack in cycle N -> instr_valid in N+1; ex_done in M -> imem_req in M+1 at new pc. Ack in same cycle as req is legal.
//  next_pc, evaluated only in the ex_done cycle, priority high->low:
//   Exception: pc<=EXC_VECTOR, epc<=pc (faulting instr).
//   irq_pend:  pc<=IRQ_VECTOR, epc<=normal next_pc, irq_pend<=0, irq_ack=1 that cycle.
//   Jump=11: {rs_data[31:2],2'b00}.  Jump=10: {pc_plus4[31:28],instr[25:0],2'b00}.
//   Jump=01 & Branch & branch_taken: pc_plus4 + {sext(instr[15:0]),2'b00}; otherwise pc_plus4.
//  Arithmetic mod 2^32; PC wraps silently. Low two PC bits always 0.
//  irq_pend set whenever irq=1 (any state); sampled only at ex_done boundary. Exception and pending irq together:
//   Exception wins, irq_pend remains set, taken at next retire.
//  ex_done outside ISSUE and imem_ack outside FETCH ignored. reset_n low mid-fetch drops imem_req immediately; a late ack after reset is ignored (state IDLE).
// CONFIGURATION
//  FETCH_PERF_EN defined: adds outputs retire_cnt[31:0] (+1 per ex_done in ISSUE) and stall_cnt[31:0] (+1 per FETCH cycle without imem_ack);
//   both reset to 0, wrap at 2^32.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Package fetch_pkg: state enum {IDLE,FETCH,ISSUE}; Jump codes JMP_SEQ/JMP_BR/JMP_J/JMP_JR; opcode constants shared with ctl.
//  Sub-module next_pc_calc (combinational): pc, instr, Jump, Branch, branch_taken, rs_data -> sequential next_pc.
//  Exception/irq priority, epc and FSM stay in fetch_unit.
// TESTING
//  Reset release, imem acks after 2 cycles with 32'h2008_0005 -> imem_addr=0, instr_valid 3 cycles after req, opCode=6'h08.
//  beq at pc=0x40, imm=16'hFFFE, Jump=01, Branch=1, taken=1, ex_done -> next imem_addr=0x3C; taken=0 -> 0x44.
//  jal at pc=0x1000_0010, instr[25:0]=26'h40 -> imem_addr=0x1000_0100; pc_plus4=0x1000_0014 during ISSUE.
//  jr with rs_data=0x0000_0123 -> imem_addr=0x0000_0120.
//  irq pulse during FETCH at pc=0x80, plain instr retires -> imem_addr=0x200, epc=0x84, irq_ack one cycle.
//  Exception and irq together at pc=0x90 -> imem_addr=0x180, epc=0x90; next retire -> 0x200, irq_ack.

Source files
------------

// File: rtl/fetch_pkg.sv
//==============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction fetch unit.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } fetch_state_t;

  // Jump selector as produced by the control decoder
  localparam logic [1:0] JMP_SEQ = 2'b00;
  localparam logic [1:0] JMP_BR  = 2'b01;
  localparam logic [1:0] JMP_J   = 2'b10;
  localparam logic [1:0] JMP_JR  = 2'b11;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [5:0] FN_JR    = 6'h08;

  // Word-scaled, sign-extended branch displacement
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/next_pc_calc.sv
//==============================================================================
// Module      : next_pc_calc
// Description : Combinational sequential-flow next PC (seq/branch/j/jr).
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module next_pc_calc
  import fetch_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [25:0] i_target,
  input  logic [1:0]  i_jump,
  input  logic        i_branch,
  input  logic        i_branch_taken,
  input  logic [29:0] i_rs_word,
  output logic [31:0] o_pc_plus4,
  output logic [31:0] o_next_pc
);

  logic [31:0] w_pc_plus4;
  logic [31:0] w_br_target;

  assign w_pc_plus4  = i_pc + 32'd4;
  assign w_br_target = w_pc_plus4 + branch_offset(i_target[15:0]);
  assign o_pc_plus4  = w_pc_plus4;

  always_comb begin
    o_next_pc = w_pc_plus4;
    case (i_jump)
      JMP_JR:  o_next_pc = {i_rs_word, 2'b00};
      JMP_J:   o_next_pc = {w_pc_plus4[31:28], i_target, 2'b00};
      JMP_BR:  o_next_pc = (i_branch && i_branch_taken) ? w_br_target : w_pc_plus4;
      default: o_next_pc = w_pc_plus4;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
//==============================================================================
// Module      : fetch_unit
// Description : PC sequencer with req/ack instruction fetch, exception and
//               interrupt redirect. Define FETCH_PERF_EN for retire/stall
//               performance counters.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0180,
  parameter logic [31:0] IRQ_VECTOR = 32'h0000_0200
)(
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opCode,
  output logic [5:0]  funct,
  output logic        instr_valid,
  input  logic        ex_done,
  input  logic        Branch,
  input  logic [1:0]  Jump,
  input  logic        branch_taken,
  input  logic [31:0] rs_data,
  input  logic        Exception,
  input  logic        irq,
  output logic [31:0] pc_plus4,
  output logic [31:0] epc,
  output logic        irq_ack
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] retire_cnt,
  output logic [31:0] stall_cnt
`endif
);

  localparam logic [31:0] c_reset_pc = {RESET_PC[31:2],   2'b00};
  localparam logic [31:0] c_exc_vec  = {EXC_VECTOR[31:2], 2'b00};
  localparam logic [31:0] c_irq_vec  = {IRQ_VECTOR[31:2], 2'b00};

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;

  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_epc;
  logic        r_irq_pend;

  logic        w_load_instr;
  logic        w_retire;
  logic [31:0] w_seq_next;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_epc_nxt;
  logic        w_take_irq;
  logic        w_unused_ok;

  // jr target is word aligned, so the low rs bits never matter
  assign w_unused_ok = &{1'b0, rs_data[1:0]};

  next_pc_calc u_next_pc_calc (
    .i_pc           (r_pc),
    .i_target       (r_instr[25:0]),
    .i_jump         (Jump),
    .i_branch       (Branch),
    .i_branch_taken (branch_taken),
    .i_rs_word      (rs_data[31:2]),
    .o_pc_plus4     (pc_plus4),
    .o_next_pc      (w_seq_next)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    imem_req     = 1'b0;
    instr_valid  = 1'b0;
    w_load_instr = 1'b0;
    w_retire     = 1'b0;
    case (r_state)
      IDLE: begin
        w_state_nxt = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          w_load_instr = 1'b1;
          w_state_nxt  = ISSUE;
        end
      end
      ISSUE: begin
        instr_valid = 1'b1;
        if (ex_done) begin
          w_retire    = 1'b1;
          w_state_nxt = FETCH;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Exception beats a pending interrupt; the interrupt stays pending
  always_comb begin
    w_pc_nxt   = w_seq_next;
    w_epc_nxt  = r_epc;
    w_take_irq = 1'b0;
    if (Exception) begin
      w_pc_nxt  = c_exc_vec;
      w_epc_nxt = r_pc;
    end else if (r_irq_pend) begin
      w_pc_nxt   = c_irq_vec;
      w_epc_nxt  = w_seq_next;
      w_take_irq = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc       <= c_reset_pc;
      r_instr    <= 32'h0;
      r_epc      <= 32'h0;
      r_irq_pend <= 1'b0;
    end else begin
      if (w_load_instr) begin
        r_instr <= imem_rdata;
      end
      if (w_retire) begin
        r_pc  <= w_pc_nxt;
        r_epc <= w_epc_nxt;
      end
      if (irq) begin
        r_irq_pend <= 1'b1;
      end else if (w_retire && w_take_irq) begin
        r_irq_pend <= 1'b0;
      end
    end
  end

  assign imem_addr = r_pc;
  assign instr     = r_instr;
  assign opCode    = r_instr[31:26];
  assign funct     = r_instr[5:0];
  assign epc       = r_epc;
  assign irq_ack   = w_retire && w_take_irq;

`ifdef FETCH_PERF_EN
  logic [31:0] r_retire_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_retire_cnt <= 32'h0;
      r_stall_cnt  <= 32'h0;
    end else begin
      if (w_retire) begin
        r_retire_cnt <= r_retire_cnt + 32'd1;
      end
      if (imem_req && !imem_ack) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign retire_cnt = r_retire_cnt;
  assign stall_cnt  = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
//==============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit with a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] EXC_PC = 32'h0000_0180;
  localparam logic [31:0] IRQ_PC = 32'h0000_0200;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  opCode;
  logic [5:0]  funct;
  logic        instr_valid;
  logic        ex_done;
  logic        Branch;
  logic [1:0]  Jump;
  logic        branch_taken;
  logic [31:0] rs_data;
  logic        Exception;
  logic        irq;
  logic [31:0] pc_plus4;
  logic [31:0] epc;
  logic        irq_ack;
`ifdef FETCH_PERF_EN
  logic [31:0] retire_cnt;
  logic [31:0] stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  fetch_unit #(.RESET_PC(RST_PC), .EXC_VECTOR(EXC_PC), .IRQ_VECTOR(IRQ_PC)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .opCode(opCode), .funct(funct), .instr_valid(instr_valid),
    .ex_done(ex_done), .Branch(Branch), .Jump(Jump), .branch_taken(branch_taken),
    .rs_data(rs_data), .Exception(Exception), .irq(irq),
    .pc_plus4(pc_plus4), .epc(epc), .irq_ack(irq_ack)
`ifdef FETCH_PERF_EN
    , .retire_cnt(retire_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  logic [31:0] m_pc, m_instr, m_epc, m_retire, m_stall;
  logic        m_pend, m_started, m_have;

  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] ins,
                                             input logic [1:0] jmp, input logic br,
                                             input logic tk, input logic [31:0] rs);
    logic [31:0] p4;
    logic signed [31:0] disp;
    logic [31:0] res;
    p4   = pc + 32'd4;
    disp = {{16{ins[15]}}, ins[15:0]};
    res  = p4;
    if (jmp == 2'd3)                   res = rs & 32'hFFFF_FFFC;
    else if (jmp == 2'd2)              res = (p4 & 32'hF000_0000) | ({6'd0, ins[25:0]} * 32'd4);
    else if (jmp == 2'd1 && br && tk)  res = p4 + 32'(disp * 4);
    return res;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pc <= RST_PC; m_instr <= '0; m_epc <= '0; m_pend <= 1'b0;
      m_started <= 1'b0; m_have <= 1'b0; m_retire <= '0; m_stall <= '0;
    end else begin
      if (irq) m_pend <= 1'b1;
      if (!m_started) begin
        m_started <= 1'b1;
      end else if (!m_have) begin
        if (imem_ack) begin
          m_instr <= imem_rdata;
          m_have  <= 1'b1;
        end else begin
          m_stall <= m_stall + 1;
        end
      end else if (ex_done) begin
        m_have   <= 1'b0;
        m_retire <= m_retire + 1;
        if (Exception) begin
          m_epc <= m_pc;
          m_pc  <= EXC_PC;
        end else if (m_pend) begin
          m_epc <= model_next(m_pc, m_instr, Jump, Branch, branch_taken, rs_data);
          m_pc  <= IRQ_PC;
          if (!irq) m_pend <= 1'b0;
        end else begin
          m_pc <= model_next(m_pc, m_instr, Jump, Branch, branch_taken, rs_data);
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_req",   imem_req,    32'h0);
      chk("rst_addr",  imem_addr,   RST_PC);
      chk("rst_valid", instr_valid, 32'h0);
      chk("rst_instr", instr,       32'h0);
      chk("rst_epc",   epc,         32'h0);
      chk("rst_pc4",   pc_plus4,    RST_PC + 32'd4);
      chk("rst_ack",   irq_ack,     32'h0);
    end else begin
      chk("req",    imem_req,    32'(m_started && !m_have));
      chk("addr",   imem_addr,   m_pc);
      chk("pc4",    pc_plus4,    m_pc + 32'd4);
      chk("valid",  instr_valid, 32'(m_have));
      chk("instr",  instr,       m_instr);
      chk("opcode", opCode,      32'(m_instr[31:26]));
      chk("funct",  funct,       32'(m_instr[5:0]));
      chk("epc",    epc,         m_epc);
      chk("irqack", irq_ack,     32'(m_have && ex_done && !Exception && m_pend));
`ifdef FETCH_PERF_EN
      chk("retire_cnt", retire_cnt, m_retire);
      chk("stall_cnt",  stall_cnt,  m_stall);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input logic [31:0] exp_addr, input string name);
    int n = 0;
    while (!imem_req && n < 20) begin
      tick();
      n++;
    end
    chk({name, "_reqseen"}, imem_req, 32'h1);
    chk({name, "_addr"}, imem_addr, exp_addr);
  endtask

  task automatic do_fetch(input logic [31:0] exp_addr, input logic [31:0] word,
                          input int delay, input logic pulse_irq, input string name);
    wait_req(exp_addr, name);
    for (int i = 0; i < delay; i++) begin
      if (pulse_irq && i == 0) irq = 1'b1;
      tick();
      irq = 1'b0;
    end
    chk({name, "_heldreq"}, imem_req, 32'h1);
    chk({name, "_notyet"}, instr_valid, 32'h0);
    imem_ack   = 1'b1;
    imem_rdata = word;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    chk({name, "_valid"}, instr_valid, 32'h1);
    chk({name, "_instr"}, instr, word);
  endtask

  task automatic do_retire(input logic [1:0] jmp, input logic br, input logic tk,
                           input logic [31:0] rs, input logic exc,
                           input logic [31:0] exp_next, input logic exp_ack, input string name);
    Jump = jmp; Branch = br; branch_taken = tk; rs_data = rs; Exception = exc;
    ex_done = 1'b1;
    #1;
    chk({name, "_irqack"}, irq_ack, 32'(exp_ack));
    tick();
    ex_done = 1'b0; Jump = JMP_SEQ; Branch = 1'b0; branch_taken = 1'b0;
    rs_data = 32'h0; Exception = 1'b0;
    chk({name, "_next"}, imem_addr, exp_next);
    chk({name, "_req"}, imem_req, 32'h1);
    chk({name, "_ackdrop"}, irq_ack, 32'h0);
  endtask

  initial begin
    reset_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0; ex_done = 1'b0;
    Branch = 1'b0; Jump = JMP_SEQ; branch_taken = 1'b0; rs_data = 32'h0;
    Exception = 1'b0; irq = 1'b0;
    repeat (2) tick();
    chk("init_req", imem_req, 32'h0);
    chk("init_pc4", pc_plus4, 32'h0000_0004);
    reset_n = 1'b1;

    // first fetch: ack two cycles into the request
    do_fetch(32'h0000_0000, 32'h2008_0005, 2, 1'b0, "first");
    chk("first_opcode", opCode, 32'h08);
    chk("first_funct",  funct,  32'h05);
    do_retire(JMP_JR, 1'b0, 1'b0, 32'h0000_0041, 1'b0, 32'h0000_0040, 1'b0, "to40");

    // beq taken backward, same-cycle ack
    do_fetch(32'h0000_0040, 32'h1000_FFFE, 0, 1'b0, "beq1");
    do_retire(JMP_BR, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0000_003C, 1'b0, "beq_taken");
    do_fetch(32'h0000_003C, 32'h2008_0005, 1, 1'b0, "at3c");
    do_retire(JMP_SEQ, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0000_0040, 1'b0, "seq3c");
    do_fetch(32'h0000_0040, 32'h1000_FFFE, 0, 1'b0, "beq2");
    do_retire(JMP_BR, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0000_0044, 1'b0, "beq_not");

    // stray ex_done in FETCH and stray ack in ISSUE are ignored
    wait_req(32'h0000_0044, "stray");
    ex_done = 1'b1;
    tick();
    ex_done = 1'b0;
    chk("stray_exdone_req", imem_req, 32'h1);
    do_fetch(32'h0000_0044, 32'h03E0_0008, 1, 1'b0, "jr");
    imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    tick();
    imem_ack = 1'b0; imem_rdata = 32'h0;
    chk("stray_ack_instr", instr, 32'h03E0_0008);
    do_retire(JMP_JR, 1'b0, 1'b0, 32'h0000_0123, 1'b0, 32'h0000_0120, 1'b0, "jr123");

    // jal
    do_fetch(32'h0000_0120, 32'h2008_0005, 0, 1'b0, "at120");
    do_retire(JMP_JR, 1'b0, 1'b0, 32'h1000_0010, 1'b0, 32'h1000_0010, 1'b0, "tojal");
    do_fetch(32'h1000_0010, 32'h0C00_0040, 1, 1'b0, "jal");
    chk("jal_pc4", pc_plus4, 32'h1000_0014);
    do_retire(JMP_J, 1'b0, 1'b0, 32'h0, 1'b0, 32'h1000_0100, 1'b0, "jal_tgt");

    // interrupt during fetch
    do_fetch(32'h1000_0100, 32'h2008_0005, 0, 1'b0, "at100");
    do_retire(JMP_JR, 1'b0, 1'b0, 32'h0000_0080, 1'b0, 32'h0000_0080, 1'b0, "to80");
    do_fetch(32'h0000_0080, 32'h2008_0005, 2, 1'b1, "irq80");
    do_retire(JMP_SEQ, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0000_0200, 1'b1, "irq_take");
    chk("irq_epc", epc, 32'h0000_0084);

    // exception and interrupt together
    do_fetch(32'h0000_0200, 32'h2008_0005, 0, 1'b0, "at200");
    do_retire(JMP_JR, 1'b0, 1'b0, 32'h0000_0090, 1'b0, 32'h0000_0090, 1'b0, "to90");
    do_fetch(32'h0000_0090, 32'hFC00_0000, 1, 1'b1, "illegal");
    do_retire(JMP_SEQ, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0180, 1'b0, "exc_take");
    chk("exc_epc", epc, 32'h0000_0090);
    do_fetch(32'h0000_0180, 32'h2008_0005, 1, 1'b0, "at180");
    do_retire(JMP_SEQ, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0000_0200, 1'b1, "irq_late");
    chk("late_epc", epc, 32'h0000_0184);

    // PC wrap
    do_fetch(32'h0000_0200, 32'h2008_0005, 0, 1'b0, "at200b");
    do_retire(JMP_JR, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFC, 1'b0, "totop");
    do_fetch(32'hFFFF_FFFC, 32'h2008_0005, 0, 1'b0, "top");
    chk("wrap_pc4", pc_plus4, 32'h0000_0000);
    do_retire(JMP_SEQ, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0000_0000, 1'b0, "wrap");

    // reset mid-fetch, late ack ignored
    wait_req(32'h0000_0000, "midrst");
    reset_n = 1'b0;
    #1;
    chk("midrst_req", imem_req, 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEC;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    imem_ack = 1'b0; imem_rdata = 32'h0;
    chk("late_ack_instr", instr, 32'h0);
    chk("late_ack_valid", instr_valid, 32'h0);
    do_fetch(32'h0000_0000, 32'h2008_0005, 1, 1'b0, "after_rst");
    do_retire(JMP_SEQ, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0000_0004, 1'b0, "seq0");
    chk("final_epc", epc, 32'h0000_0000);

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
